// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane masked word RAM behind a valid/ready load/store channel.
// Optional macro DMEM_ERR_EN enables misalignment/out-of-range detection on resp_err.
module dmem_responder #(
    parameter int unsigned DEPTH       = 2048,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_mem_op,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [4:0]            req_rd,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [4:0]            resp_rd,
    output logic                  resp_err
);

    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [3:0]  WS_INIT    = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LH  = 4'd1,
        OP_LW  = 4'd2,
        OP_LBU = 4'd3,
        OP_LHU = 4'd4,
        OP_SB  = 4'd5,
        OP_SH  = 4'd6,
        OP_SW  = 4'd7,
        OP_NOP = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    ready_q, ready_d;
    logic [3:0]              op_q, op_d;
    logic [31:0]             addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [4:0]              rd_q, rd_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [4:0]              resp_rd_q, resp_rd_d;
    logic                    err_q, err_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    accept;
    logic                    access;
    logic                    in_idle;
    logic [3:0]              acc_op;
    logic [31:0]             acc_addr;
    logic [31:0]             acc_wdata;
    logic [4:0]              acc_rd;
    logic [31:0]             eff_addr;
    logic                    acc_err;
    logic                    is_store;
    logic                    is_half;
    logic                    is_word;
    logic [1:0]              lane;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [3:0]              be;
    logic [31:0]             wlane;
    logic [DATA_WIDTH-1:0]   rword;
    logic [7:0]              rbyte;
    logic [15:0]             rhalf;
    logic [31:0]             ext;
    logic                    mem_we;

    assign accept     = req_valid && ready_q;
    assign req_ready  = ready_q;
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_rd    = resp_rd_q;
    assign resp_err   = err_q;

    // With zero wait states the access happens on the acceptance edge, so the
    // live request fields are used while idle and the latched copy afterwards.
    assign in_idle   = (state_q == S_IDLE);
    assign acc_op    = in_idle ? req_mem_op : op_q;
    assign acc_addr  = in_idle ? req_addr   : addr_q;
    assign acc_wdata = in_idle ? req_wdata  : wdata_q;
    assign acc_rd    = in_idle ? req_rd     : rd_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        access  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && (req_mem_op < OP_NOP)) begin
                    op_d    = req_mem_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rd_d    = req_rd;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WS_INIT;
                    end else begin
                        state_d = S_RESP;
                        access  = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    always_comb begin
        is_store = (acc_op == OP_SB) || (acc_op == OP_SH) || (acc_op == OP_SW);
        is_half  = (acc_op == OP_LH) || (acc_op == OP_LHU) || (acc_op == OP_SH);
        is_word  = (acc_op == OP_LW) || (acc_op == OP_SW);
`ifdef DMEM_ERR_EN
        eff_addr = acc_addr;
        acc_err  = (is_half && acc_addr[0]) || (is_word && (acc_addr[1:0] != 2'b00)) ||
                   (|acc_addr[31:ADDR_WIDTH+2]);
`else
        eff_addr = acc_addr;
        if (is_half) eff_addr[0] = 1'b0;
        if (is_word) eff_addr[1:0] = 2'b00;
        acc_err  = 1'b0;
`endif
        lane  = eff_addr[1:0];
        idx   = eff_addr[ADDR_WIDTH+1:2];
        be    = 4'b0000;
        wlane = acc_wdata;
        case (acc_op)
            OP_SB: begin
                be    = 4'b0001 << lane;
                wlane = {4{acc_wdata[7:0]}};
            end
            OP_SH: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wlane = {2{acc_wdata[15:0]}};
            end
            OP_SW: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        rword = mem[idx];
        rbyte = rword[{lane, 3'b000} +: 8];
        rhalf = lane[1] ? rword[31:16] : rword[15:0];
        case (acc_op)
            OP_LB:   ext = {{24{rbyte[7]}}, rbyte};
            OP_LBU:  ext = {24'd0, rbyte};
            OP_LH:   ext = {{16{rhalf[15]}}, rhalf};
            OP_LHU:  ext = {16'd0, rhalf};
            OP_LW:   ext = rword;
            default: ext = '0;
        endcase
        mem_we = access && is_store && !acc_err;
    end

`ifndef DMEM_ERR_EN
    logic unused_addr_hi;
    assign unused_addr_hi = ^acc_addr[31:ADDR_WIDTH+2];
`endif

    always_comb begin
        rdata_d   = rdata_q;
        resp_rd_d = resp_rd_q;
        err_d     = err_q;
        if (access) begin
            rdata_d   = (acc_err || is_store) ? '0 : ext;
            resp_rd_d = acc_rd;
            err_d     = acc_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            op_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= '0;
            rdata_q   <= '0;
            resp_rd_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            rdata_q   <= rdata_d;
            resp_rd_q <= resp_rd_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with 0 wait states, one with 3.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 2048;
    localparam logic [3:0] LB = 4'd0, LH = 4'd1, LW = 4'd2, LBU = 4'd3, LHU = 4'd4;
    localparam logic [3:0] SB = 4'd5, SH = 4'd6, SW = 4'd7, NOP = 4'd8;
`ifdef DMEM_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_mem_op [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [4:0]  req_rd     [2];
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [31:0] resp_rdata [2];
    logic [4:0]  resp_rd    [2];
    logic [1:0]  resp_err;

    exp_t sb_q[$];
    int   checks;
    int   errors;

    dmem_responder #(.DEPTH(DEPTH), .DATA_WIDTH(32), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_mem_op(req_mem_op[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_rd(req_rd[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
        .resp_rd(resp_rd[0]), .resp_err(resp_err[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .DATA_WIDTH(32), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_mem_op(req_mem_op[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_rd(req_rd[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
        .resp_rd(resp_rd[1]), .resp_err(resp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic xact(input int d, input string tag, input logic [3:0] op,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                        input logic [31:0] exp_data, input logic exp_err, input int stall);
        int   n;
        exp_t e;
        @(negedge clk);
        req_valid[d]  = 1'b1;
        req_mem_op[d] = op;
        req_addr[d]   = addr;
        req_wdata[d]  = wdata;
        req_rd[d]     = rd;
        resp_ready[d] = (stall == 0);
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) begin
            check({tag, "_acc_timeout"}, 32'(req_ready[d]), 32'd1);
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        if (op > SW) begin
            repeat (5) begin
                @(negedge clk);
                check({tag, "_nop_valid"}, 32'(resp_valid[d]), 32'd0);
                check({tag, "_nop_ready"}, 32'(req_ready[d]), 32'd1);
            end
            return;
        end
        sb_q.push_back('{data: exp_data, rd: rd, err: exp_err});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid[d] && n < 40);
        check({tag, "_latency"}, 32'(n), 32'(1 + ws_of(d)));
        if (!resp_valid[d]) begin
            void'(sb_q.pop_front());
            return;
        end
        e = sb_q.pop_front();
        repeat (stall) begin
            check({tag, "_stall_rdata"}, resp_rdata[d], e.data);
            check({tag, "_stall_rd"}, 32'(resp_rd[d]), 32'(e.rd));
            check({tag, "_stall_ready"}, 32'(req_ready[d]), 32'd0);
            @(negedge clk);
            check({tag, "_stall_valid"}, 32'(resp_valid[d]), 32'd1);
        end
        resp_ready[d] = 1'b1;
        check({tag, "_rdata"}, resp_rdata[d], e.data);
        check({tag, "_rd"}, 32'(resp_rd[d]), 32'(e.rd));
        check({tag, "_err"}, 32'(resp_err[d]), 32'(e.err));
        check({tag, "_busy"}, 32'(req_ready[d]), 32'd0);
        @(negedge clk);
        check({tag, "_post_ready"}, 32'(req_ready[d]), 32'd1);
        check({tag, "_post_valid"}, 32'(resp_valid[d]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = '1;
        for (int i = 0; i < 2; i++) begin
            req_mem_op[i] = NOP;
            req_addr[i]   = '0;
            req_wdata[i]  = '0;
            req_rd[i]     = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", 32'(req_ready[i]), 32'd0);
            check("rst_valid", 32'(resp_valid[i]), 32'd0);
            check("rst_rdata", resp_rdata[i], 32'd0);
            check("rst_err", 32'(resp_err[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", 32'(req_ready[0]), 32'd1);
        check("rel_valid", 32'(resp_valid[0]), 32'd0);

        // Basic word path and byte/halfword lanes on the zero-wait instance.
        xact(0, "sw10",  SW,  32'h10, 32'hDEADBEEF, 5'd1, 32'h0, 1'b0, 0);
        xact(0, "lw10",  LW,  32'h10, 32'h0,        5'd5, 32'hDEADBEEF, 1'b0, 0);
        xact(0, "sw20",  SW,  32'h20, 32'h0,        5'd2, 32'h0, 1'b0, 0);
        xact(0, "sb23",  SB,  32'h23, 32'h12345680, 5'd3, 32'h0, 1'b0, 0);
        xact(0, "sh20",  SH,  32'h20, 32'hABCD1234, 5'd4, 32'h0, 1'b0, 0);
        xact(0, "lw20",  LW,  32'h20, 32'h0, 5'd6,  32'h80001234, 1'b0, 0);
        xact(0, "lb23",  LB,  32'h23, 32'h0, 5'd7,  32'hFFFFFF80, 1'b0, 0);
        xact(0, "lbu23", LBU, 32'h23, 32'h0, 5'd8,  32'h00000080, 1'b0, 0);
        xact(0, "lh20",  LH,  32'h20, 32'h0, 5'd9,  32'h00001234, 1'b0, 0);
        xact(0, "lhu22", LHU, 32'h22, 32'h0, 5'd10, 32'h00008000, 1'b0, 0);
        xact(0, "lh22",  LH,  32'h22, 32'h0, 5'd11, 32'hFFFF8000, 1'b0, 0);
        xact(0, "lb20",  LB,  32'h20, 32'h0, 5'd12, 32'h00000034, 1'b0, 0);

        // Misaligned / out-of-range: flagged with the check enabled, masked/wrapped without.
        xact(0, "lw12",  LW,  32'h12, 32'h0, 5'd13, ERR ? 32'h0 : 32'hDEADBEEF, ERR, 0);
        xact(0, "sw13",  SW,  32'h13, 32'hA5A5A5A5, 5'd14, 32'h0, ERR, 0);
        xact(0, "lw10b", LW,  32'h10, 32'h0, 5'd15, ERR ? 32'hDEADBEEF : 32'hA5A5A5A5, 1'b0, 0);
        xact(0, "sh21",  SH,  32'h21, 32'h0000BEEF, 5'd16, 32'h0, ERR, 0);
        xact(0, "lw20b", LW,  32'h20, 32'h0, 5'd17, ERR ? 32'h80001234 : 32'h8000BEEF, 1'b0, 0);
        xact(0, "sw00",  SW,  32'h0,  32'h01020304, 5'd18, 32'h0, 1'b0, 0);
        xact(0, "swoor", SW,  DEPTH * 4, 32'h00000055, 5'd19, 32'h0, ERR, 0);
        xact(0, "lw00",  LW,  32'h0,  32'h0, 5'd20, ERR ? 32'h01020304 : 32'h00000055, 1'b0, 0);
        xact(0, "nop",   NOP,   32'h10, 32'hFFFFFFFF, 5'd21, 32'h0, 1'b0, 0);
        xact(0, "undef", 4'hA,  32'h10, 32'hFFFFFFFF, 5'd22, 32'h0, 1'b0, 0);
        xact(0, "lw10c", LW,  32'h10, 32'h0, 5'd23, ERR ? 32'hDEADBEEF : 32'hA5A5A5A5, 1'b0, 0);

        // Wait states and response backpressure.
        xact(1, "w_sw40", SW, 32'h40, 32'h11111111, 5'd1, 32'h0, 1'b0, 0);
        xact(1, "w_lw40", LW, 32'h40, 32'h0, 5'd7, 32'h11111111, 1'b0, 5);

        // Reset while a store is still waiting: it must not land in RAM.
        @(negedge clk);
        req_valid[1]  = 1'b1;
        req_mem_op[1] = SW;
        req_addr[1]   = 32'h40;
        req_wdata[1]  = 32'h22222222;
        req_rd[1]     = 5'd3;
        check("mid_ready", 32'(req_ready[1]), 32'd1);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(resp_valid[1]), 32'd0);
        check("mid_rst_ready", 32'(req_ready[1]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xact(1, "w_lw40b", LW, 32'h40, 32'h0, 5'd9, 32'h11111111, 1'b0, 0);
        xact(0, "lw10d",   LW, 32'h10, 32'h0, 5'd4, ERR ? 32'hDEADBEEF : 32'hA5A5A5A5, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
